// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@60 raster timing with pixel-latency aligned syncs.
// Define VGA_TIMING_FRAME_COUNT_EN to add the FrameCount[15:0] output.
module vga_timing_gen #(
    parameter int H_VISIBLE     = 800,
    parameter int H_FRONT       = 40,
    parameter int H_SYNC        = 128,
    parameter int H_BACK        = 88,
    parameter int V_VISIBLE     = 600,
    parameter int V_FRONT       = 1,
    parameter int V_SYNC        = 4,
    parameter int V_BACK        = 23,
    parameter bit SYNC_POS      = 1'b1,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    output logic [10:0] X,
    output logic [9:0]  Y,
    output logic        Visible,
    output logic        LineStart,
    output logic        FrameStart,
    input  logic [2:0]  RGBIn,
    output logic        R,
    output logic        G,
    output logic        B,
    output logic        HSync,
`ifdef VGA_TIMING_FRAME_COUNT_EN
    output logic [15:0] FrameCount,
`endif
    output logic        VSync
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_VIS   = 12'(H_VISIBLE);
    localparam logic [11:0] HS_BEG  = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_END  = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
    localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 4) begin : g_bad_latency
            $error("vga_timing_gen: PIXEL_LATENCY must be 0..4");
        end
        if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: raster exceeds 11/10-bit counters");
        end
    endgenerate

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [11:0] x_ext;
    logic [10:0] y_ext;
    logic        h_last;
    logic        v_last;
    logic        vis_raw;
    logic        hs_raw;
    logic        vs_raw;

    assign x_ext  = {1'b0, x_q};
    assign y_ext  = {1'b0, y_q};
    assign h_last = (x_ext == H_LAST);
    assign v_last = (y_ext == V_LAST);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (Enable) begin
            if (h_last) begin
                x_d = '0;
                y_d = v_last ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign vis_raw = (x_ext < H_VIS) && (y_ext < V_VIS);
    assign hs_raw  = (x_ext >= HS_BEG) && (x_ext < HS_END);
    assign vs_raw  = (y_ext >= VS_BEG) && (y_ext < VS_END);

    assign X          = x_q;
    assign Y          = y_q;
    assign Visible    = vis_raw;
    // Gated by Reset too, so no pulse is seen while the raster is held in reset
    assign LineStart  = Reset && Enable && (x_q == 11'd0);
    assign FrameStart = Reset && Enable && (x_q == 11'd0) && (y_q == 10'd0);

    logic [2:0] sig_raw;
    logic [2:0] sig_dly;

    assign sig_raw = {vis_raw, hs_raw, vs_raw};

    // Timing flags travel alongside the pixel source's own latency
    generate
        if (PIXEL_LATENCY == 0) begin : g_wire
            assign sig_dly = sig_raw;
        end else begin : g_dly
            logic [2:0] dly_q [PIXEL_LATENCY];

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    for (int i = 0; i < PIXEL_LATENCY; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q[0] <= sig_raw;
                    for (int i = 1; i < PIXEL_LATENCY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign sig_dly = dly_q[PIXEL_LATENCY-1];
        end
    endgenerate

    logic       vis_dly;
    logic       hs_dly;
    logic       vs_dly;
    logic [2:0] rgb_q, rgb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

    assign {vis_dly, hs_dly, vs_dly} = sig_dly;

    always_comb begin
        rgb_d = '0;
        if (Enable) begin
            rgb_d = RGBIn & {3{vis_dly}};
        end
        hs_d = hs_dly ^ !SYNC_POS;
        vs_d = vs_dly ^ !SYNC_POS;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rgb_q <= '0;
            hs_q  <= !SYNC_POS;
            vs_q  <= !SYNC_POS;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign R     = rgb_q[2];
    assign G     = rgb_q[1];
    assign B     = rgb_q[0];
    assign HSync = hs_q;
    assign VSync = vs_q;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] fc_q, fc_d;

    always_comb begin
        fc_d = fc_q;
        if (Enable && h_last && v_last) begin
            fc_d = fc_q + 16'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign FrameCount = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a reduced raster (35x12 clocks,
// latency 2) so several full frames fit in a short run.
module tb_vga_timing_gen;

    localparam int HV  = 20;
    localparam int HF  = 4;
    localparam int HS  = 6;
    localparam int HB  = 5;
    localparam int VV  = 6;
    localparam int VF  = 1;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int LAT = 2;
    localparam int HT  = HV + HF + HS + HB;
    localparam int VT  = VV + VF + VS + VB;
    localparam int FRM = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] X;
    logic [9:0]  Y;
    logic        Visible;
    logic        LineStart;
    logic        FrameStart;
    logic [2:0]  rgb_in;
    logic        R;
    logic        G;
    logic        B;
    logic        HSync;
    logic        VSync;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] FrameCount;
`endif

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POS(1'b1), .PIXEL_LATENCY(LAT)
    ) dut (
        .Clock(clk),
        .Reset(rst_n),
        .Enable(en),
        .X(X),
        .Y(Y),
        .Visible(Visible),
        .LineStart(LineStart),
        .FrameStart(FrameStart),
        .RGBIn(rgb_in),
        .R(R),
        .G(G),
        .B(B),
        .HSync(HSync),
`ifdef VGA_TIMING_FRAME_COUNT_EN
        .FrameCount(FrameCount),
`endif
        .VSync(VSync)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 25)
                $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    logic pix_all;

    function automatic logic [2:0] pix(input int x, input int y);
        logic [2:0] p;
        if (pix_all) p = 3'b111;
        else p = {x[0] ^ y[0], x[1], y[0]};
        return p;
    endfunction

    // Pixel source: answers LAT clocks after X/Y are presented
    logic [2:0] src_q [LAT];
    always @(posedge clk) begin
        src_q[0] <= pix(int'(X), int'(Y));
        for (int i = 1; i < LAT; i++) src_q[i] <= src_q[i-1];
    end
    assign rgb_in = src_q[LAT-1];

    int mx, my, mfc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx <= 0; my <= 0; mfc <= 0;
        end else if (en) begin
            if (mx == HT - 1) begin
                mx <= 0;
                if (my == VT - 1) begin
                    my <= 0;
                    mfc <= (mfc + 1) % 65536;
                end else my <= my + 1;
            end else mx <= mx + 1;
        end
    end

    typedef struct packed {
        logic       vis;
        logic       hs;
        logic       vs;
        logic [2:0] pix;
    } ent_t;

    ent_t sbq[$];
    logic en_prev;
    int   cnt_left = 0;
    int   ls_cnt = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0, r_cnt = 0;
    int   fs_first = -1, fs_second = -1, hs_rise = -1, r_first = -1;
    logic hs_prev;

    always @(negedge clk) begin
        ent_t e;
        ent_t cur;
        int idx;
        if (!rst_n) begin
            sbq.delete();
            for (int i = 0; i < LAT; i++) sbq.push_back('0);
            hs_prev = 1'b0;
        end else begin
            if (sbq.size() == LAT + 1) begin
                e = sbq.pop_front();
                chk("rgb", int'({R, G, B}),
                    (en_prev && e.vis) ? int'(e.pix) : 0);
                chk("hsync", int'(HSync), int'(e.hs));
                chk("vsync", int'(VSync), int'(e.vs));
            end
            chk("x", int'(X), mx);
            chk("y", int'(Y), my);
            chk("vis", int'(Visible), int'(mx < HV && my < VV));
            chk("linestart", int'(LineStart), int'(en && mx == 0));
            chk("framestart", int'(FrameStart),
                int'(en && mx == 0 && my == 0));
`ifdef VGA_TIMING_FRAME_COUNT_EN
            chk("framecount", int'(FrameCount), mfc);
`endif
            cur.vis = (mx < HV) && (my < VV);
            cur.hs  = (mx >= HV + HF) && (mx < HV + HF + HS);
            cur.vs  = (my >= VV + VF) && (my < VV + VF + VS);
            cur.pix = pix(mx, my);
            sbq.push_back(cur);
            en_prev = en;
            if (cnt_left > 0) begin
                idx = 2 * FRM - cnt_left;
                if (LineStart) ls_cnt++;
                if (FrameStart) begin
                    fs_cnt++;
                    if (fs_first < 0) fs_first = idx;
                    else if (fs_second < 0) fs_second = idx;
                end
                if (HSync) hs_cnt++;
                if (VSync) vs_cnt++;
                if (R) r_cnt++;
                if (HSync && !hs_prev && hs_rise < 0) hs_rise = idx;
                if (R && r_first < 0) r_first = idx;
                hs_prev = HSync;
                cnt_left--;
            end
        end
    end

    task automatic wait_model(input int x, input int y, input int fc);
        bit hit = 0;
        for (int i = 0; i < 4 * FRM; i++) begin
            @(posedge clk);
            #1;
            if (mx == x && my == y && mfc >= fc) begin
                hit = 1;
                break;
            end
        end
        chk("wait_timeout", int'(hit), 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        pix_all = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_x", int'(X), 0);
        chk("rst_y", int'(Y), 0);
        chk("rst_rgb", int'({R, G, B}), 0);
        chk("rst_hsync", int'(HSync), 0);
        chk("rst_vsync", int'(VSync), 0);
        chk("rst_linestart", int'(LineStart), 0);
        chk("rst_framestart", int'(FrameStart), 0);

        rst_n    = 1'b1;
        cnt_left = 2 * FRM;
        #1;
        chk("rel_framestart", int'(FrameStart), 1);
        for (int i = 0; i < 3 * FRM && cnt_left > 0; i++) @(posedge clk);
        chk("window_timeout", cnt_left, 0);
        chk("linestart_cnt", ls_cnt, 2 * VT);
        chk("framestart_cnt", fs_cnt, 2);
        chk("frame_period", fs_second - fs_first, FRM);
        chk("hsync_cnt", hs_cnt, 2 * VT * HS);
        chk("vsync_cnt", vs_cnt, 2 * VS * HT);
        chk("r_cnt", r_cnt, 2 * HV * VV);
        chk("hsync_rise", hs_rise, HV + HF + LAT + 1);
        chk("r_first", r_first, LAT + 1);

        pix_all = 1'b0;
        wait_model(10, 3, 0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_x", int'(X), 10);
            chk("hold_y", int'(Y), 3);
            chk("hold_rgb", int'({R, G, B}), 0);
            chk("hold_ls", int'(LineStart), 0);
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("resume_x", int'(X), 11);

        wait_model(HV + HF + 4, VV + VF, 3);
        chk("pre_hsync", int'(HSync), 1);
        chk("pre_vsync", int'(VSync), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_hsync", int'(HSync), 0);
        chk("async_vsync", int'(VSync), 0);
        chk("async_x", int'(X), 0);
        chk("async_y", int'(Y), 0);
        chk("async_fs", int'(FrameStart), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel2_framestart", int'(FrameStart), 1);
        repeat (2 * HT) @(posedge clk);
        #1;
        chk("rel2_y", int'(Y), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
